dct_block_sched: RTL and testbench

Frame-level scheduler that drives the dct_2d core one 8x8 block at a time in raster order over an image of IMG_W_BLOCKS x IMG_H_BLOCKS blocks. For each block it requests a load from the block fetcher and pulses dct_2d start_block. It then waits for block_done and holds a valid/ready handshake until the downstream quantiser/entropy stage accepts the coefficients. It sits between the frame buffer fetch logic and the dct_2d instance, and supervises the core with a done-timeout.

---
 rtl/dct_block_sched.sv | 162 ++++++++++++++++
 tb/tb_dct_block_sched.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_block_sched.sv
// dct_block_sched: frame-level scheduler that walks an IMG_W_BLOCKS x
// IMG_H_BLOCKS image in raster order, one 8x8 block at a time. For each block
// it requests a load, pulses the dct_2d start, waits for completion under a
// done-timeout, and then holds coef_valid until downstream accepts the block.
// All outputs are registered. There are no combinational input-to-output paths.
module dct_block_sched #(
  parameter int IMG_W_BLOCKS = 4,
  parameter int IMG_H_BLOCKS = 4,
  parameter int DONE_TIMEOUT = 1023,
  localparam int XW = (IMG_W_BLOCKS > 1) ? $clog2(IMG_W_BLOCKS) : 1,
  localparam int YW = (IMG_H_BLOCKS > 1) ? $clog2(IMG_H_BLOCKS) : 1,
  localparam int CW = $clog2(DONE_TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic          abort,
  output logic          frame_busy,
  output logic          frame_done,
  output logic          timeout_err,
  output logic          load_req,
  input  logic          load_ack,
  output logic [XW-1:0] blk_x,
  output logic [YW-1:0] blk_y,
  output logic          dct_start_block,
  input  logic          dct_block_done,
  output logic          coef_valid,
  input  logic          coef_ready
);

  localparam logic [XW-1:0] X_LAST  = XW'(IMG_W_BLOCKS - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H_BLOCKS - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DONE_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_t;

  state_t        r_state;
  logic          r_busy;
  logic          r_fdone;
  logic          r_terr;
  logic          r_lreq;
  logic          r_start;
  logic          r_valid;
  logic [XW-1:0] r_bx;
  logic [YW-1:0] r_by;
  logic [CW-1:0] r_cnt;

  logic [CW-1:0] w_cnt_inc;
  logic          w_last_blk;

  // In WAIT, w_cnt_inc equals the number of cycles elapsed since the start
  // pulse. The cycle where it equals DONE_TIMEOUT is the last one in which a
  // done is accepted.
  assign w_cnt_inc  = r_cnt + CW'(1);
  assign w_last_blk = (r_bx == X_LAST) && (r_by == Y_LAST);

  assign frame_busy      = r_busy;
  assign frame_done      = r_fdone;
  assign timeout_err     = r_terr;
  assign load_req        = r_lreq;
  assign blk_x           = r_bx;
  assign blk_y           = r_by;
  assign dct_start_block = r_start;
  assign coef_valid      = r_valid;

  // Frame sequencer: state plus every registered output, with abort overriding all transitions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_fdone <= 1'b0;
      r_terr  <= 1'b0;
      r_lreq  <= 1'b0;
      r_start <= 1'b0;
      r_valid <= 1'b0;
      r_bx    <= '0;
      r_by    <= '0;
      r_cnt   <= '0;
    end else begin
      r_start <= 1'b0;
      r_fdone <= 1'b0;
      if (abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_lreq  <= 1'b0;
        r_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (frame_start) begin
              r_state <= S_LOAD;
              r_busy  <= 1'b1;
              r_lreq  <= 1'b1;
              r_terr  <= 1'b0;
              r_bx    <= '0;
              r_by    <= '0;
            end
          end
          S_LOAD: begin
            if (load_ack) begin
              r_state <= S_START;
              r_lreq  <= 1'b0;
              r_start <= 1'b1;
            end
          end
          S_START: begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (dct_block_done) begin
              r_state <= S_EMIT;
              r_valid <= 1'b1;
            end else if (w_cnt_inc == CNT_MAX) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_terr  <= 1'b1;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          S_EMIT: begin
            if (coef_ready) begin
              r_valid <= 1'b0;
              if (w_last_blk) begin
                r_state <= S_DONE;
                r_fdone <= 1'b1;
              end else begin
                r_state <= S_LOAD;
                r_lreq  <= 1'b1;
                if (r_bx == X_LAST) begin
                  r_bx <= '0;
                  r_by <= r_by + YW'(1);
                end else begin
                  r_bx <= r_bx + XW'(1);
                end
              end
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_lreq  <= 1'b0;
            r_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dct_block_sched.sv
// tb_dct_block_sched: randomized scoreboard bench for dct_block_sched.
// Stimulus pushes the expected event sequence of each frame (start pulses,
// handshakes, frame_done, timeout) into a queue. A negedge monitor pops and
// compares whenever the DUT shows such an event, and checks cycle latencies
// against the previous cycle's inputs.
module tb_dct_block_sched;

  localparam int W = 3;
  localparam int H = 2;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fs_m = 1'b0, fs_n = 1'b0, abort = 1'b0;
  logic ack_f = 1'b0, ack_n = 1'b0, done_r = 1'b0, done_n = 1'b0, ready = 1'b0;
  logic frame_start, load_ack, dct_block_done;
  assign frame_start    = fs_m | fs_n;
  assign load_ack       = ack_f | ack_n;
  assign dct_block_done = done_r | done_n;

  logic       frame_busy, frame_done, timeout_err, load_req, dct_start_block, coef_valid;
  logic [1:0] blk_x;
  logic [0:0] blk_y;

  logic       d_busy, d_done, d_terr, d_lreq, d_start, d_valid;
  logic [1:0] d_bx, d_by;

  dct_block_sched #(.IMG_W_BLOCKS(W), .IMG_H_BLOCKS(H), .DONE_TIMEOUT(D)) u_dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .abort(abort),
    .frame_busy(frame_busy), .frame_done(frame_done), .timeout_err(timeout_err),
    .load_req(load_req), .load_ack(load_ack), .blk_x(blk_x), .blk_y(blk_y),
    .dct_start_block(dct_start_block), .dct_block_done(dct_block_done),
    .coef_valid(coef_valid), .coef_ready(ready)
  );

  // Default-parameter instance, only used for the quiet-after-reset check.
  dct_block_sched u_def (
    .clk(clk), .rst_n(rst_n), .frame_start(1'b0), .abort(1'b0),
    .frame_busy(d_busy), .frame_done(d_done), .timeout_err(d_terr),
    .load_req(d_lreq), .load_ack(1'b0), .blk_x(d_bx), .blk_y(d_by),
    .dct_start_block(d_start), .dct_block_done(1'b0),
    .coef_valid(d_valid), .coef_ready(1'b0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  // dct_mode: 0 latency 1..D, 1 latency exactly D, 2 never, 3 latency 2..D
  int dct_mode = 0;
  // ready_mode: 0 random, 1 always, 2 ten cycles low at each EMIT
  int ready_mode = 1;
  bit noise_en = 1'b0;

  typedef struct { int kind; int x; int y; } ev_t;  // kind 0 start,1 emit,2 fdone,3 timeout
  ev_t exp_q[$];

  function automatic int b(input logic v);
    return v ? 1 : 0;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: actual %0d required %0d", nm, cyc, act, req);
    end
  endtask

  task automatic pop_chk(input string nm, input int kind, input int x, input int y);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk({nm, "_unexpected"}, kind * 100 + x * 10 + y, -1);
    end else begin
      e = exp_q.pop_front();
      chk(nm, kind * 100 + x * 10 + y, e.kind * 100 + e.x * 10 + e.y);
    end
  endtask

  task automatic push_ev(input int kind, input int x, input int y);
    ev_t e;
    e.kind = kind; e.x = x; e.y = y;
    exp_q.push_back(e);
  endtask

  // Reference plan for a full frame: raster order, start then emit per block.
  task automatic push_full_frame();
    for (int i = 0; i < W * H; i++) begin
      push_ev(0, i % W, i / W);
      push_ev(1, i % W, i / W);
    end
    push_ev(2, W - 1, H - 1);
  endtask

  // Fetcher: acks after a random 0..3 cycle delay once load_req is seen.
  initial begin
    int fwait = -1;
    forever begin
      @(posedge clk); #1;
      ack_f = 1'b0;
      if (load_req) begin
        if (fwait < 0) fwait = int'($urandom_range(0, 3));
        if (fwait == 0) begin ack_f = 1'b1; fwait = -1; end
        else fwait--;
      end else begin
        fwait = -1;
      end
    end
  end

  // DCT core model: done pulse a chosen number of cycles after each start pulse.
  initial begin
    int dcnt = 0;
    forever begin
      @(posedge clk); #1;
      done_r = 1'b0;
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) done_r = 1'b1;
      end
      if (dct_start_block) begin
        case (dct_mode)
          0: dcnt = int'($urandom_range(1, D));
          1: dcnt = D;
          3: dcnt = int'($urandom_range(2, D));
          default: dcnt = 0;
        endcase
      end
    end
  end

  // Downstream ready.
  initial begin
    int ecnt = 0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: ready = ($urandom % 2) == 0;
        1: ready = 1'b1;
        default: begin
          if (coef_valid) begin
            if (ecnt < 10) begin ready = 1'b0; ecnt++; end
            else ready = 1'b1;
          end else begin
            ecnt = 0;
            ready = 1'b0;
          end
        end
      endcase
    end
  end

  // Spurious pulses, injected only in states where they must be ignored.
  initial begin
    forever begin
      @(posedge clk); #1;
      ack_n  = noise_en && !load_req && ($urandom % 5 == 0);
      done_n = noise_en && (load_req || coef_valid) && ($urandom % 5 == 0);
      fs_n   = noise_en && frame_busy && ($urandom % 5 == 0);
    end
  end

  // Monitor: scoreboard pops plus cycle-relationship checks.
  logic prev_rst = 1'b0, prev_abort = 1'b0, prev_fs = 1'b0, prev_busy = 1'b0;
  logic prev_lreq = 1'b0, prev_ack = 1'b0, prev_start = 1'b0, prev_valid = 1'b0;
  logic prev_ready = 1'b0, prev_fdone = 1'b0, prev_done = 1'b0, prev_terr = 1'b0;
  int   px = 0, py = 0;
  int   ws = -1;

  initial begin
    forever begin
      int ix, iy, idx;
      @(negedge clk);
      ix = int'(blk_x);
      iy = int'(blk_y);
      if (!prev_rst) begin
        chk("reset_outs", b(frame_busy) * 1000000 + b(frame_done) * 100000 + b(timeout_err) * 10000 +
            b(load_req) * 1000 + b(dct_start_block) * 100 + b(coef_valid) * 10 + ix + iy, 0);
        ws = -1;
      end else if (prev_abort) begin
        chk("abort_outs", b(load_req) * 10000 + b(dct_start_block) * 1000 + b(coef_valid) * 100 +
            b(frame_done) * 10 + b(frame_busy), 0);
        chk("abort_terr", b(timeout_err), b(prev_terr));
        ws = -1;
      end else begin
        if (prev_fs && !prev_busy)
          chk("fstart_lat", b(load_req) * 10000 + b(frame_busy) * 1000 + b(timeout_err) * 100 + ix * 10 + iy, 11000);
        if (prev_lreq && !prev_ack)
          chk("lreq_hold", b(load_req) * 100 + ix * 10 + iy, 100 + px * 10 + py);
        if (prev_lreq && prev_ack)
          chk("ack_start_lat", b(dct_start_block), 1);
        if (prev_start)
          chk("start_pulse", b(dct_start_block), 0);
        if (prev_valid && !prev_ready)
          chk("valid_hold", b(coef_valid) * 1000 + b(load_req) * 100 + ix * 10 + iy, 1000 + px * 10 + py);
        if (prev_valid && prev_ready) begin
          idx = py * W + px;
          if (idx == W * H - 1)
            chk("hs_done", b(frame_done) * 10 + b(load_req), 10);
          else
            chk("hs_next", b(load_req) * 100 + ix * 10 + iy, 100 + ((idx + 1) % W) * 10 + (idx + 1) / W);
        end
        if (prev_fdone)
          chk("done_pulse", b(frame_done) * 10 + b(frame_busy), 0);
        if (ws >= 0 && prev_done && (cyc - 1) >= ws + 1 && (cyc - 1) <= ws + D) begin
          chk("done_valid", b(coef_valid), 1);
          ws = -1;
        end else if (ws >= 0 && cyc == ws + D + 1) begin
          chk("timeout_lat", b(timeout_err) * 10 + b(frame_busy), 10);
          ws = -1;
        end
      end
      if (dct_start_block) begin
        pop_chk("ev_start", 0, ix, iy);
        ws = cyc;
      end
      if (coef_valid && ready) pop_chk("ev_emit", 1, ix, iy);
      if (frame_done) pop_chk("ev_fdone", 2, ix, iy);
      if (timeout_err && !prev_terr) pop_chk("ev_timeout", 3, ix, iy);
      prev_rst = rst_n; prev_abort = abort; prev_fs = frame_start; prev_busy = frame_busy;
      prev_lreq = load_req; prev_ack = load_ack; prev_start = dct_start_block;
      prev_valid = coef_valid; prev_ready = ready; prev_fdone = frame_done;
      prev_done = dct_block_done; prev_terr = timeout_err;
      px = ix; py = iy;
    end
  end

  task automatic pulse_fs();
    @(posedge clk); #1 fs_m = 1'b1;
    @(posedge clk); #1 fs_m = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_busy && n < 3000);
    chk("frame_end", b(frame_busy), 0);
  endtask

  task automatic run_frame(input int dm, input int rm, input bit ne);
    dct_mode = dm; ready_mode = rm; noise_en = ne;
    push_full_frame();
    pulse_fs();
    wait_idle();
    repeat (3) @(negedge clk);
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic run_timeout();
    dct_mode = 2; ready_mode = 1; noise_en = 1'b1;
    push_ev(0, 0, 0);
    push_ev(3, 0, 0);
    pulse_fs();
    wait_idle();
    repeat (3) @(negedge clk);
    chk("drain_timeout", exp_q.size(), 0);
    chk("terr_sticky", b(timeout_err), 1);
  endtask

  task automatic run_abort();
    int starts = 0;
    int n = 0;
    dct_mode = 3; ready_mode = 1; noise_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_ev(0, i % W, i / W);
      if (i < 2) push_ev(1, i % W, i / W);
    end
    pulse_fs();
    while (starts < 3 && n < 3000) begin
      @(negedge clk);
      n++;
      if (dct_start_block) starts++;
    end
    chk("abort_reach", starts, 3);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    repeat (D + 4) @(negedge clk);
    chk("drain_abort", exp_q.size(), 0);
    chk("abort_idle", b(frame_busy), 0);
  endtask

  task automatic run_reset_emit();
    int n = 0;
    dct_mode = 0; ready_mode = 2; noise_en = 1'b0;
    push_full_frame();
    pulse_fs();
    while (!coef_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("reset_reach", b(coef_valid), 1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("reset_idle", b(frame_busy) * 10 + b(coef_valid), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_def", b(d_busy) * 100000 + b(d_done) * 10000 + b(d_terr) * 1000 + b(d_lreq) * 100 +
          b(d_start) * 10 + b(d_valid) + int'(d_bx) + int'(d_by), 0);
      chk("idle_dut", b(frame_busy) * 100000 + b(frame_done) * 10000 + b(timeout_err) * 1000 +
          b(load_req) * 100 + b(dct_start_block) * 10 + b(coef_valid) + int'(blk_x) + int'(blk_y), 0);
    end
    run_frame(0, 1, 1'b0);
    run_frame(0, 2, 1'b1);
    for (int i = 0; i < 4; i++) run_frame(0, 0, 1'b1);
    run_timeout();
    run_frame(1, 0, 1'b1);
    run_abort();
    run_reset_emit();
    run_frame(0, 0, 1'b1);
    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog at cycle %0d: actual still running, required finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
